// File: rtl/sram_mmio_responder_if.sv
// Core-side SRAM port bundle: an instruction fetch port and a data load/store port.
// The core drives requests through master; the responder answers through slave.
interface sram_mmio_responder_if;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, data_sram_rdata
    );

    modport slave (
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, data_sram_rdata
    );
endinterface

// File: rtl/sram_mmio_responder.sv
// Shared word RAM behind the core's inst/data SRAM ports, plus a small MMIO window
// holding LED, switch, free-running timer, compare and timer-interrupt status.
module sram_mmio_responder #(
    parameter int          ADDR_W  = 12,
    parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
    input  logic                        clk,
    input  logic                        rst,
    sram_mmio_responder_if.slave        bus,
    input  logic [7:0]                  switch_in,
    output logic [15:0]                 led_out,
    output logic [5:0]                  int_out
);

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_COUNT   = 16'h0008;
    localparam logic [15:0] OFF_COMPARE = 16'h000C;
    localparam logic [15:0] OFF_STATUS  = 16'h0010;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    logic [31:0]       r_mem [2**ADDR_W];
    logic [31:0]       r_inst_rdata;
    logic [31:0]       r_data_rdata;
    logic [15:0]       r_led;
    logic [31:0]       r_count;
    logic [31:0]       r_compare;
    logic              r_pending;

    logic [ADDR_W-1:0] w_inst_idx;
    logic [ADDR_W-1:0] w_data_idx;
    logic              w_inst_mmio;
    logic              w_data_mmio;
    logic [15:0]       w_off;
    logic              w_data_wr;
    logic              w_ram_wr;
    logic              w_mmio_wr;
    logic              w_wr_led;
    logic              w_wr_count;
    logic              w_wr_compare;
    logic              w_wr_status;
    logic              w_match;
    logic              w_clear;
    logic [31:0]       w_led_merged;
    logic [31:0]       w_mmio_rdata;
    logic              w_unused_bits;

    assign w_inst_idx   = bus.inst_sram_addr[ADDR_W+1:2];
    assign w_data_idx   = bus.data_sram_addr[ADDR_W+1:2];
    assign w_inst_mmio  = (bus.inst_sram_addr[31:16] == MMIO_HI);
    assign w_data_mmio  = (bus.data_sram_addr[31:16] == MMIO_HI);
    assign w_off        = bus.data_sram_addr[15:0];

    assign w_data_wr    = bus.data_sram_en && (bus.data_sram_wen != 4'h0);
    assign w_ram_wr     = w_data_wr && !w_data_mmio && !rst;
    assign w_mmio_wr    = w_data_wr && w_data_mmio;
    assign w_wr_led     = w_mmio_wr && (w_off == OFF_LED);
    assign w_wr_count   = w_mmio_wr && (w_off == OFF_COUNT);
    assign w_wr_compare = w_mmio_wr && (w_off == OFF_COMPARE);
    assign w_wr_status  = w_mmio_wr && (w_off == OFF_STATUS);

    assign w_match      = (r_compare != 32'h0) && (r_count == r_compare);
    assign w_clear      = w_wr_compare ||
                          (w_wr_status && bus.data_sram_wen[0] && bus.data_sram_wdata[0]);
    assign w_led_merged = merge_bytes({16'h0, r_led}, bus.data_sram_wdata, bus.data_sram_wen);

    // Inst write lanes/data never store; address bits outside index/decode are don't-care.
    assign w_unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata, bus.inst_sram_addr,
                             bus.data_sram_addr, w_led_merged[31:16]};

    // NOTE: every output of a combinational block is defaulted first so no path infers a latch.
    always_comb begin
        w_mmio_rdata = 32'h0;
        case (w_off)
            OFF_LED:     w_mmio_rdata = {16'h0, r_led};
            OFF_SWITCH:  w_mmio_rdata = {24'h0, switch_in};
            OFF_COUNT:   w_mmio_rdata = r_count;
            OFF_COMPARE: w_mmio_rdata = r_compare;
            OFF_STATUS:  w_mmio_rdata = {31'h0, r_pending};
            default:     w_mmio_rdata = 32'h0;
        endcase
    end

    // NOTE: the RAM array has no reset; only the write enable is gated so reset suppresses stores.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) r_mem[w_data_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: non-blocking assignments make both ports read the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            if (bus.inst_sram_en) r_inst_rdata <= w_inst_mmio ? 32'h0 : r_mem[w_inst_idx];
            if (bus.data_sram_en) r_data_rdata <= w_data_mmio ? w_mmio_rdata : r_mem[w_data_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= 16'h0;
            r_count   <= 32'h0;
            r_compare <= 32'h0;
            r_pending <= 1'b0;
        end else begin
            if (w_wr_led) r_led <= w_led_merged[15:0];
            r_count <= w_wr_count ? merge_bytes(r_count, bus.data_sram_wdata, bus.data_sram_wen)
                                  : r_count + 32'd1;
            if (w_wr_compare) r_compare <= merge_bytes(r_compare, bus.data_sram_wdata, bus.data_sram_wen);
            // A match in the same cycle as a clear keeps the interrupt pending.
            if (w_match)      r_pending <= 1'b1;
            else if (w_clear) r_pending <= 1'b0;
        end
    end

    assign bus.inst_sram_rdata = r_inst_rdata;
    assign bus.data_sram_rdata = r_data_rdata;
    assign led_out             = r_led;
    assign int_out             = {r_pending, 5'b0};

endmodule

// File: tb/tb_sram_mmio_responder.sv
// Scoreboard bench for sram_mmio_responder: drivers queue expected read words,
// a monitor pops and compares whenever a port sampled en=1 on the previous edge.
module tb_sram_mmio_responder;

    localparam logic [31:0] A_LED     = 32'hbfaf_0000;
    localparam logic [31:0] A_SWITCH  = 32'hbfaf_0004;
    localparam logic [31:0] A_COUNT   = 32'hbfaf_0008;
    localparam logic [31:0] A_COMPARE = 32'hbfaf_000C;
    localparam logic [31:0] A_STATUS  = 32'hbfaf_0010;
    localparam logic [31:0] A_UNMAP   = 32'hbfaf_0020;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  switch_in = 8'h00;
    logic [15:0] led_out;
    logic [5:0]  int_out;

    int n_checks = 0;
    int n_errors = 0;
    exp_t iq[$];
    exp_t dq[$];

    sram_mmio_responder_if bus ();

    sram_mmio_responder #(.ADDR_W(12), .MMIO_HI(16'hbfaf)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .switch_in (switch_in),
        .led_out   (led_out),
        .int_out   (int_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic d_drv(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                         input logic chk, input logic [31:0] exp, input string name);
        exp_t e;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        e.chk = chk; e.exp = exp; e.name = name;
        dq.push_back(e);
    endtask

    task automatic i_drv(input logic [31:0] addr, input logic chk, input logic [31:0] exp,
                         input string name);
        exp_t e;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = addr;
        e.chk = chk; e.exp = exp; e.name = name;
        iq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.inst_sram_en   = 1'b0;
        bus.inst_sram_wen  = 4'h0;
        bus.data_sram_en   = 1'b0;
        bus.data_sram_wen  = 4'h0;
    endtask

    // Counts edges until the timer interrupt rises; required distance is 21 edges.
    task automatic wait_irq(input string name);
        int got;
        got = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (int_out[5]) begin
                got = n;
                break;
            end
        end
        check(name, got, 21);
        check({name, "_lines"}, {26'h0, int_out}, 32'h20);
    endtask

    initial begin : monitor
        logic vi, vd;
        exp_t e;
        forever begin
            @(posedge clk);
            vi = bus.inst_sram_en && !rst;
            vd = bus.data_sram_en && !rst;
            @(negedge clk);
            if (vi) begin
                if (iq.size() == 0) check("inst_queue_underflow", 32'h1, 32'h0);
                else begin
                    e = iq.pop_front();
                    if (e.chk) check(e.name, bus.inst_sram_rdata, e.exp);
                end
            end
            if (vd) begin
                if (dq.size() == 0) check("data_queue_underflow", 32'h1, 32'h0);
                else begin
                    e = dq.pop_front();
                    if (e.chk) check(e.name, bus.data_sram_rdata, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        bus.inst_sram_en    = 1'b0;
        bus.inst_sram_wen   = 4'h0;
        bus.inst_sram_addr  = 32'h0;
        bus.inst_sram_wdata = 32'h0;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        tick(); tick();
        check("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
        check("rst_data_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_led", {16'h0, led_out}, 32'h0);
        check("rst_int", {26'h0, int_out}, 32'h0);
        rst = 1'b0;

        // Byte-lane merge at 0x100.
        d_drv(32'h0000_0100, 4'hF, 32'h1122_3344, 1'b0, 32'h0, "");
        tick();
        d_drv(32'h0000_0100, 4'b0101, 32'hAABB_CCDD, 1'b1, 32'h1122_3344, "write_returns_old");
        tick();
        d_drv(32'h0000_0100, 4'h0, 32'h0, 1'b1, 32'h11BB_33DD, "lane_merge");
        tick();

        // Read-first collision between a data write and an inst fetch.
        d_drv(32'h0000_0200, 4'hF, 32'h1234_5678, 1'b0, 32'h0, "");
        tick();
        d_drv(32'h0000_0200, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, "data_read_first");
        i_drv(32'h0000_0200, 1'b1, 32'h1234_5678, "inst_collision");
        tick();
        i_drv(32'h0000_0200, 1'b1, 32'hDEAD_BEEF, "inst_after_write");
        tick();
        i_drv(32'h8000_0202, 1'b1, 32'hDEAD_BEEF, "inst_high_bits_ignored");
        tick();

        // LED, switch, unmapped offset, MMIO fetch.
        d_drv(A_LED, 4'hF, 32'hFFFF_5A5A, 1'b0, 32'h0, "");
        tick();
        check("led_out", {16'h0, led_out}, 32'h0000_5A5A);
        d_drv(A_LED, 4'h0, 32'h0, 1'b1, 32'h0000_5A5A, "led_read");
        tick();
        d_drv(A_LED, 4'b0010, 32'h0000_A500, 1'b0, 32'h0, "");
        tick();
        check("led_byte_lane", {16'h0, led_out}, 32'h0000_A55A);
        switch_in = 8'hC3;
        d_drv(A_SWITCH, 4'h0, 32'h0, 1'b1, 32'h0000_00C3, "switch_read");
        tick();
        d_drv(A_UNMAP, 4'hF, 32'h1234_5678, 1'b0, 32'h0, "");
        tick();
        d_drv(A_UNMAP, 4'h0, 32'h0, 1'b1, 32'h0, "unmapped_read");
        tick();
        i_drv(32'hbfaf_0000, 1'b1, 32'h0, "inst_mmio_fetch");
        tick();

        // COUNT wrap and write priority over increment.
        d_drv(A_COUNT, 4'hF, 32'hFFFF_FFFE, 1'b0, 32'h0, "");
        tick();
        tick();
        d_drv(A_COUNT, 4'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, "count_pre_wrap");
        tick();
        d_drv(A_COUNT, 4'h0, 32'h0, 1'b1, 32'h0000_0000, "count_wrapped");
        tick();
        d_drv(A_COUNT, 4'hF, 32'h0000_1000, 1'b0, 32'h0, "");
        tick();
        d_drv(A_COUNT, 4'h0, 32'h0, 1'b1, 32'h0000_1000, "count_load_exact");
        tick();

        // Timer: match, W1C clear, then COMPARE-write clear.
        d_drv(A_COMPARE, 4'hF, 32'd20, 1'b0, 32'h0, "");
        tick();
        d_drv(A_COUNT, 4'hF, 32'd0, 1'b0, 32'h0, "");
        tick();
        check("irq_idle", {26'h0, int_out}, 32'h0);
        wait_irq("irq_rise_1");
        d_drv(A_STATUS, 4'hF, 32'h1, 1'b1, 32'h1, "status_pending");
        tick();
        check("irq_w1c", {26'h0, int_out}, 32'h0);
        d_drv(A_STATUS, 4'h0, 32'h0, 1'b1, 32'h0, "status_cleared");
        tick();
        d_drv(A_COUNT, 4'hF, 32'd0, 1'b0, 32'h0, "");
        tick();
        wait_irq("irq_rise_2");
        d_drv(A_COMPARE, 4'hF, 32'd20, 1'b0, 32'h0, "");
        tick();
        check("irq_compare_clear", {26'h0, int_out}, 32'h0);
        d_drv(A_COMPARE, 4'h0, 32'h0, 1'b1, 32'd20, "compare_read");
        tick();
        d_drv(A_COUNT, 4'hF, 32'd0, 1'b0, 32'h0, "");
        tick();
        wait_irq("irq_rise_3");

        // Reset in the same cycle as a RAM write.
        d_drv(32'h0000_0300, 4'hF, 32'h0000_0077, 1'b0, 32'h0, "");
        i_drv(32'h0000_0100, 1'b1, 32'h11BB_33DD, "inst_nonzero_before_reset");
        tick();
        rst = 1'b1;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'hF;
        bus.data_sram_addr  = 32'h0000_0300;
        bus.data_sram_wdata = 32'h0000_0055;
        tick();
        check("midrst_inst_rdata", bus.inst_sram_rdata, 32'h0);
        check("midrst_data_rdata", bus.data_sram_rdata, 32'h0);
        check("midrst_led", {16'h0, led_out}, 32'h0);
        check("midrst_int", {26'h0, int_out}, 32'h0);
        rst = 1'b0;
        d_drv(A_COUNT, 4'h0, 32'h0, 1'b1, 32'h0, "count_after_reset");
        i_drv(32'h0000_0300, 1'b1, 32'h0000_0077, "ram_kept_after_reset");
        tick();
        d_drv(32'h0000_0300, 4'h0, 32'h0, 1'b1, 32'h0000_0077, "ram_kept_data_port");
        tick();

        tick(); tick();
        check("inst_queue_drained", iq.size(), 32'h0);
        check("data_queue_drained", dq.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_mmio_responder.md
# sram_mmio_responder

Responder side of the core's `inst_sram_*` and `data_sram_*` ports. Serves instruction fetches and data loads/stores from one shared word-addressed RAM, and decodes a small MMIO window: LED, switch, free-running timer, compare, interrupt status. Sits beside the CPU core in the SoC top. Its timer interrupt drives `int[5]` of the core.

## Interface
Parameters:
- `ADDR_W`, default 12: RAM word-index width (2^ADDR_W words); index = `addr[ADDR_W+1:2]`.
- `MMIO_HI`, default 16'hbfaf: value of `addr[31:16]` that selects the MMIO window.

Ports:
- `clk`  in  1  sole clock; everything on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_sram_en`  in  1  fetch request.
- `inst_sram_wen`  in  4  ignored (port is read-only).
- `inst_sram_addr`  in  32  fetch byte address.
- `inst_sram_wdata`  in  32  ignored.
- `inst_sram_rdata`  out  32  fetched word, registered.
- `data_sram_en`  in  1  data access request.
- `data_sram_wen`  in  4  byte-lane write enables; 0 = read.
- `data_sram_addr`  in  32  data byte address.
- `data_sram_wdata`  in  32  store data.
- `data_sram_rdata`  out  32  load word, registered.
- `switch_in`  in  8  board switches.
- `led_out`  out  16  LED register.
- `int_out`  out  6  interrupt lines to the core; bit 5 = timer pending, bits 4:0 = 0.

## Operation
- **Decode:**
  - `addr[31:16]==MMIO_HI` selects MMIO, offset `addr[15:0]`.
  - Any other address selects RAM, using `addr[ADDR_W+1:2]`.
  - Address bits above the index and `addr[1:0]` are ignored.
- **RAM write:** when `data_sram_en` and wen lane i is set, byte `wdata[8i+7:8i]` is written. Other lanes are unchanged.
- **RAM read:** the addressed word is latched into rdata.
  - Read-during-write is read-first: a data access that writes returns the pre-write word.
  - An inst fetch to the same word in the same cycle also returns the pre-write word.
- **Inst port:** fetches in the MMIO window return 0.
- **MMIO map** (all RW registers honor per-byte wen):
  - 0x0000 LED: RW, bits 15:0; upper bits read 0.
  - 0x0004 SWITCH: RO, `{24'b0, switch_in}` sampled at the access edge.
  - 0x0008 COUNT: RW, 32-bit.
    - Increments by 1 every cycle and wraps 0xFFFFFFFF→0.
    - In a cycle where it is written, the written value is loaded with no increment.
  - 0x000C COMPARE: RW, 32-bit. Any write also clears pending.
  - 0x0010 STATUS: bit0 = pending; write 1 to bit0 clears it; other bits read 0.
  - Unmapped offsets read 0; writes are ignored.
- **Timer interrupt:**
  - pending sets in the cycle after a cycle where COMPARE≠0 and COUNT (pre-increment) == COMPARE.
  - If set and clear occur in the same cycle, set wins.
  - `int_out[5]` = pending.
- **Reset:**
  - Outputs: both rdata = 0, `led_out` = 0, `int_out` = 0.
  - Registers: COUNT = 0, COMPARE = 0, pending = 0.
  - RAM contents are not reset.
  - Reset overrides any simultaneous access.
  - Reset asserted mid-stream discards the access in that cycle; no write occurs.

## Timing
- Read latency is exactly 1 cycle: rdata is valid on the cycle after the edge where en=1 was sampled.
- When en=0, rdata holds its previous value.
- Writes take effect at the sampling edge; a read of the same word in the next cycle returns the new data.
- Both ports accept one access per cycle, every cycle, with no stall or handshake back-pressure.
- `led_out` updates one cycle after the write edge.
- `int_out[5]` asserts 1 cycle after the match cycle and stays high until cleared.
- MMIO reads: COUNT returns the value before that cycle's increment.

## Test plan
- **Byte-lane merge:**
  - Stimulus: write 0x11223344 to RAM 0x100 with wen=4'hF, then wdata 0xAABBCCDD with wen=4'b0101, then read.
  - Required: rdata = 0x11BB33DD one cycle after the read.
- **Read-first collision:**
  - Stimulus: same cycle, data write 0xDEADBEEF (wen=F) and inst fetch of the same word (old value 0x12345678).
  - Required: inst_rdata = 0x12345678; a fetch on the next cycle returns 0xDEADBEEF.
- **Timer:**
  - Stimulus: write COMPARE=20, COUNT=0.
  - Required: int_out[5] rises 21 cycles after the COUNT write takes effect; W1C to STATUS drops it next cycle.
  - Stimulus: in a second run, a COMPARE write is made while pending.
  - Required: it also drops.
- **Wrap and write-priority:**
  - Stimulus: write COUNT=0xFFFFFFFE, read twice back-to-back.
  - Required: read values 0xFFFFFFFF then 0x00000000.
  - Stimulus: a COUNT write in the same cycle as an increment.
  - Required: loads exactly wdata.
- **LED/switch/unmapped:**
  - Stimulus: write 0xFFFF5A5A to LED; read LED; read SWITCH with switch_in=0xC3; read offset 0x0020; fetch from 0xbfaf0000.
  - Required: led_out = 0x5A5A; LED read = 0x00005A5A; SWITCH read = 0x000000C3; offset 0x0020 = 0; MMIO fetch = 0.
- **Reset mid-operation:**
  - Stimulus: assert rst in the same cycle as a RAM write of 0x55 to an address holding 0x77.
  - Required: RAM unchanged (0x77); rdata = 0; led_out = 0; int_out = 0; COUNT reads 0 on the first access after reset.
